// File: rtl/mvm_pkg.sv
// Shared types and defaults for the matrix-vector multiply sequencer.
package mvm_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2,
    FIN     = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvm_row_dot.sv
// Combinational dot product of one A row with B; products truncated, sum wraps mod 2^WIDTH.
module mvm_row_dot
  import mvm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input  logic [N-1:0][WIDTH-1:0] a_row,
  input  logic [N-1:0][WIDTH-1:0] b_vec,
  output logic [WIDTH-1:0]        dot
);

  always_comb begin
    dot = '0;
    for (int k = 0; k < N; k++) begin
      dot = dot + a_row[k] * b_vec[k];
    end
  end

endmodule

// File: rtl/mvm_sequencer.sv
// Sequenced N x N matrix-vector multiply: one C row per cycle, then C streamed out on valid/ready.
// start at edge t gives first res_valid at t+N+1; res_idx/res_data hold while res_ready is low.
module mvm_sequencer
  import mvm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  localparam int IW   = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_vec,
  input  logic [IW-1:0]    wr_row,
  input  logic [IW-1:0]    wr_col,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IW-1:0]    res_idx,
  output logic [WIDTH-1:0] res_data,
  output logic             done,
  output logic             err
);

  localparam logic [IW:0]   N_EXT = (IW+1)'(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  state_t                         state_q, state_d;
  logic [IW-1:0]                  r_q, r_d;
  logic [N-1:0][N-1:0][WIDTH-1:0] a_q, a_d;
  logic [N-1:0][WIDTH-1:0]        b_q, b_d;
  logic [N-1:0][WIDTH-1:0]        c_q, c_d;
  logic                           err_q, err_d;
  logic                           res_valid_q, res_valid_d;
  logic [IW-1:0]                  res_idx_q, res_idx_d;
  logic [WIDTH-1:0]               res_data_q, res_data_d;

  logic             row_ok, col_ok, wr_ok;
  logic [IW-1:0]    idx_nxt;
  logic [WIDTH-1:0] row_dot;

  assign row_ok  = {1'b0, wr_row} < N_EXT;
  assign col_ok  = {1'b0, wr_col} < N_EXT;
  assign wr_ok   = wr_vec ? row_ok : (row_ok && col_ok);
  assign idx_nxt = res_idx_q + 1'b1;

  mvm_row_dot #(.WIDTH(WIDTH), .N(N)) u_row_dot (
    .a_row (a_q[r_q]),
    .b_vec (b_q),
    .dot   (row_dot)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;

    case (state_q)
      IDLE: begin
        if (wr_en) begin
          if (!wr_ok) begin
            err_d = 1'b1;
          end else if (wr_vec) begin
            b_d[wr_row] = wr_data;
          end else begin
            a_d[wr_row][wr_col] = wr_data;
          end
        end
        if (start) begin
          state_d = COMPUTE;
          r_d     = '0;
        end
      end

      COMPUTE: begin
        if (wr_en || start) err_d = 1'b1;
        c_d[r_q] = row_dot;
        if (r_q == LAST) begin
          state_d     = OUTPUT;
          res_valid_d = 1'b0;
          res_idx_d   = '0;
        end else begin
          r_d = r_q + 1'b1;
        end
      end

      OUTPUT: begin
        if (wr_en || start) err_d = 1'b1;
        // First OUTPUT cycle primes the result register from C[0].
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_data_d  = c_q[res_idx_q];
        end else if (res_ready) begin
          if (res_idx_q == LAST) begin
            state_d     = FIN;
            res_valid_d = 1'b0;
          end else begin
            res_idx_d  = idx_nxt;
            res_data_d = c_q[idx_nxt];
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy      = (state_q == COMPUTE) || (state_q == OUTPUT);
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_mvm_sequencer.sv
// Self-checking bench for mvm_sequencer against a plain-arithmetic matrix-vector model.
module tb_mvm_sequencer;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, wr_vec, start, res_ready;
  logic [IW-1:0] wr_row, wr_col;
  logic [W-1:0]  wr_data;
  logic          busy, res_valid, done, err;
  logic [IW-1:0] res_idx;
  logic [W-1:0]  res_data;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N];
  logic [W-1:0] rx [N];

  mvm_sequencer #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_vec    (wr_vec),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_idx   (res_idx),
    .res_data  (res_data),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // C[r] = sum_k A[r][k]*B[k], each product kept to W bits, sum wrapping mod 2^W.
  function automatic logic [W-1:0] exp_c(input int r);
    logic [W-1:0] s;
    logic [W-1:0] p;
    s = '0;
    for (int k = 0; k < N; k++) begin
      p = ma[r][k] * mb[k];
      s = s + p;
    end
    return s;
  endfunction

  function automatic void zero_model();
    for (int i = 0; i < N; i++) begin
      mb[i] = '0;
      for (int j = 0; j < N; j++) ma[i][j] = '0;
    end
  endfunction

  task automatic wr_a(input int r, input int c, input logic [W-1:0] v);
    wr_en = 1'b1; wr_vec = 1'b0; wr_row = IW'(r); wr_col = IW'(c); wr_data = v;
    tick();
    wr_en = 1'b0;
    if (r < N && c < N) ma[r][c] = v;
  endtask

  task automatic wr_b(input int r, input logic [W-1:0] v);
    wr_en = 1'b1; wr_vec = 1'b1; wr_row = IW'(r); wr_col = IW'($urandom_range(0, 3)); wr_data = v;
    tick();
    wr_en = 1'b0;
    if (r < N) mb[r] = v;
  endtask

  task automatic load_plan();
    int pa [9];
    int pb [3];
    pa = '{1, 0, -2, 0, 3, -1, 1, 2, 1};
    pb = '{3, -1, 4};
    for (int i = 0; i < 9; i++) wr_a(i / 3, i % 3, W'(pa[i]));
    for (int i = 0; i < 3; i++) wr_b(i, W'(pb[i]));
  endtask

  // One start..done run; results land in rx[]; timing checked unless ready is randomised.
  task automatic run(input string nm, input int stall_n, input bit rand_rdy,
                     input bit inject, input bit combo, input logic [W-1:0] combo_v);
    logic [W-1:0] exp [N];
    int first_v, done_c, ndone, got, stalls;
    if (combo) begin
      wr_en = 1'b1; wr_vec = 1'b1; wr_row = 2'd2; wr_col = 2'd0; wr_data = combo_v;
      mb[2] = combo_v;
    end
    for (int r = 0; r < N; r++) begin
      exp[r] = exp_c(r);
      rx[r]  = 'x;
    end
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    first_v = -1; done_c = -1; ndone = 0; got = 0; stalls = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (res_valid && first_v < 0) first_v = cyc;
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = cyc;
      end
      if (done_c >= 0 && cyc >= done_c + 3) break;
      if (res_valid && got == 1 && stalls < stall_n) begin
        res_ready = 1'b0;
        stalls++;
        total++;
        if (res_idx !== 2'd1 || res_data !== exp[1]) begin
          bad++;
          $display("FAIL %s stall_hold: got idx=%0d data=%h want idx=1 data=%h", nm, res_idx, res_data, exp[1]);
        end
      end else if (rand_rdy) begin
        res_ready = ($urandom_range(0, 3) != 0);
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        total++;
        if (got >= N || res_idx !== IW'(got) || res_data !== exp[got % N]) begin
          bad++;
          $display("FAIL %s result%0d: got idx=%0d data=%h want idx=%0d data=%h",
                   nm, got, res_idx, res_data, got, exp[got % N]);
        end
        if (got < N) rx[got] = res_data;
        got++;
      end
      if (inject && cyc == 1) begin
        wr_en = 1'b1; wr_vec = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'hdead_beef;
        start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      tick();
    end
    res_ready = 1'b0;
    total++;
    if (got != N) begin
      bad++;
      $display("FAIL %s result_count: got %0d want %0d", nm, got, N);
    end
    total++;
    if (ndone != 1) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d want 1", nm, ndone);
    end
    if (!rand_rdy) begin
      total++;
      if (first_v != N + 1) begin
        bad++;
        $display("FAIL %s first_valid_latency: got %0d want %0d", nm, first_v, N + 1);
      end
      total++;
      if (done_c != 2 * N + 1 + stall_n) begin
        bad++;
        $display("FAIL %s done_latency: got %0d want %0d", nm, done_c, 2 * N + 1 + stall_n);
      end
    end
  endtask

  task automatic check_plan_results(input string nm);
    logic [W-1:0] want [N];
    want = '{32'hffff_fffb, 32'hffff_fff9, 32'h0000_0005};
    for (int i = 0; i < N; i++) begin
      total++;
      if (rx[i] !== want[i]) begin
        bad++;
        $display("FAIL %s plan_c%0d: got %h want %h", nm, i, rx[i], want[i]);
      end
    end
  endtask

  task automatic check_err(input string nm, input logic want);
    total++;
    if (err !== want) begin
      bad++;
      $display("FAIL %s err: got %b want %b", nm, err, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({busy, res_valid, done, err} !== 4'b0000 || res_idx !== '0 || res_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b vld=%b done=%b err=%b idx=%0d data=%h want all 0",
               busy, res_valid, done, err, res_idx, res_data);
    end
    rst_n = 1'b1;
    tick();
    zero_model();
  endtask

  task automatic test_basic();
    load_plan();
    check_err("basic_pre", 1'b0);
    run("basic", 0, 1'b0, 1'b0, 1'b0, '0);
    check_plan_results("basic");
  endtask

  task automatic test_stall();
    run("stall", 3, 1'b0, 1'b0, 1'b0, '0);
    check_plan_results("stall");
  endtask

  task automatic test_busy_err();
    check_err("busy_pre", 1'b0);
    run("busy_inject", 0, 1'b0, 1'b1, 1'b0, '0);
    check_err("busy_post", 1'b1);
    check_plan_results("busy_inject");
    run("busy_rerun", 0, 1'b0, 1'b0, 1'b0, '0);
    check_plan_results("busy_rerun");
    check_err("busy_sticky", 1'b1);
  endtask

  task automatic test_wrap();
    wr_a(0, 0, 32'h8000_0000);
    wr_a(0, 1, '0);
    wr_a(0, 2, '0);
    wr_b(0, 32'd2);
    wr_b(1, '0);
    wr_b(2, '0);
    run("wrap", 0, 1'b0, 1'b0, 1'b0, '0);
    total++;
    if (rx[0] !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap_c0: got %h want 00000000", rx[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    load_plan();
    start = 1'b1;
    tick();
    start = 1'b0;
    res_ready = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (res_valid && res_idx == 2'd1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_mid_reach_idx1: got timeout want res_idx=1");
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({busy, res_valid, done, err} !== 4'b0000 || res_data !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got busy=%b vld=%b done=%b err=%b data=%h want all 0",
               busy, res_valid, done, err, res_data);
    end
    rst_n = 1'b1;
    res_ready = 1'b0;
    zero_model();
    tick();
    run("reset_mid_rerun", 0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < N; i++) begin
      total++;
      if (rx[i] !== '0) begin
        bad++;
        $display("FAIL reset_mid_zero_c%0d: got %h want 00000000", i, rx[i]);
      end
    end
  endtask

  task automatic test_bad_idx();
    load_plan();
    check_err("bad_idx_pre", 1'b0);
    wr_a(3, 0, 32'h5555_5555);
    check_err("bad_idx_row", 1'b1);
    wr_a(0, 3, 32'h7777_7777);
    wr_b(3, 32'h6666_6666);
    run("bad_idx", 0, 1'b0, 1'b0, 1'b0, '0);
    check_plan_results("bad_idx");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) wr_a(i, j, $urandom);
        wr_b(i, $urandom);
      end
      run("random", 0, 1'b1, 1'b0, 1'b1, $urandom);
      run("random_repeat", 0, 1'b0, 1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_vec = 1'b0; wr_row = '0; wr_col = '0;
    wr_data = '0; start = 1'b0; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_busy_err();
    test_wrap();
    test_reset_mid();
    test_bad_idx();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
